// File: rtl/serial_subtractor_8b.sv
// serial_subtractor_8b: bit-serial a - b, LSB first, one borrow flop; result, borrow and signed overflow held after a done pulse.
module serial_subtractor_8b #(
    parameter int BIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [BIT-1:0] a,
    input  logic [BIT-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [BIT-1:0] diff,
    output logic           borrow,
    output logic           ovf
);
    localparam int CW = $clog2(BIT);
    localparam logic [CW-1:0] LAST = CW'(BIT - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [BIT-1:0] sa, sb, res;
    logic [CW-1:0] cnt;
    logic br, am, bm, d, br_nx, last;
    always_comb begin
        d = sa[0] ^ sb[0] ^ br;
        br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last = cnt == LAST;
        state_nx = state;
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa <= '0;
            sb <= '0;
            res <= '0;
            cnt <= '0;
            br <= 1'b0;
            am <= 1'b0;
            bm <= 1'b0;
            diff <= '0;
            borrow <= 1'b0;
            ovf <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                sa <= a;
                sb <= b;
                am <= a[BIT-1];
                bm <= b[BIT-1];
                br <= 1'b0;
                cnt <= '0;
            end
            if (state == RUN) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                res <= {d, res[BIT-1:1]};
                br <= br_nx;
                cnt <= cnt + 1'b1;
                // the last bit-step lands straight in the held outputs; d is the result MSB
                if (last) begin
                    diff <= {d, res[BIT-1:1]};
                    borrow <= br_nx;
                    ovf <= (am ^ bm) & (am ^ d);
                end
            end
        end
    end
endmodule
